// File: rtl/gate_sweep_pkg.sv
// Shared state encoding, default geometry and reference truth tables for the gate sweep controller.
package gate_sweep_pkg;

   typedef logic [1:0] state_t;

   localparam state_t StIdle = 2'd0;
   localparam state_t StRun  = 2'd1;
   localparam state_t StDone = 2'd2;

   localparam int unsigned DefWidth = 2;
   localparam int unsigned DefDwell = 4;

   // Bit v is the expected output for input vector v ({a,b}, a = MSB).
   localparam logic [3:0] TblAnd = 4'b1000;
   localparam logic [3:0] TblOr  = 4'b1110;
   localparam logic [3:0] TblXor = 4'b0110;

endpackage

// File: rtl/gate_sweep_dwell.sv
// Dwell counter: counts 0..DWELL-1 while enabled and strobes `last` on the final cycle of a window.
module gate_sweep_dwell #(
   parameter int unsigned DWELL = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic last
);

   localparam int unsigned CntW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(DWELL - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   assign last = enable && (cnt_q == CntMax);

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = last ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Exhaustive input sweep of a combinational gate, checked against a latched truth table.
// Define GATE_SWEEP_LOG_EN to add the per-vector fail_mask output.
module gate_sweep_ctrl
   import gate_sweep_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth,
   parameter int unsigned DWELL = DefDwell
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [2**WIDTH-1:0]   truth_tbl,
   input  logic                  y,
   output logic [WIDTH-1:0]      vec_out,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [WIDTH:0]        err_cnt,
   output logic [WIDTH-1:0]      first_fail
`ifdef GATE_SWEEP_LOG_EN
   ,
   output logic [2**WIDTH-1:0]   fail_mask
`endif
);

   localparam int unsigned NumVec = 2**WIDTH;
   localparam logic [WIDTH:0] ErrMax = (WIDTH+1)'(NumVec);
   localparam logic [WIDTH-1:0] LastVec = WIDTH'(NumVec - 1);

   state_t            state_q, state_d;
   logic [NumVec-1:0] tbl_q;
   logic [WIDTH-1:0]  vec_q, vec_d;
   logic [WIDTH:0]    err_q, err_d;
   logic [WIDTH-1:0]  ff_q, ff_d;
`ifdef GATE_SWEEP_LOG_EN
   logic [NumVec-1:0] mask_q, mask_d;
`endif

   logic accept;
   logic sample;

   // start and abort together in IDLE is a no-op.
   assign accept = (state_q == StIdle) && start && !abort;

   gate_sweep_dwell #(
      .DWELL (DWELL)
   ) u_dwell (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (accept || abort),
      .enable (state_q == StRun),
      .last   (sample)
   );

   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      err_d   = err_q;
      ff_d    = ff_q;
`ifdef GATE_SWEEP_LOG_EN
      mask_d  = mask_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = StRun;
               vec_d   = '0;
               err_d   = '0;
               ff_d    = '0;
`ifdef GATE_SWEEP_LOG_EN
               mask_d  = '0;
`endif
            end
         end
         StRun: begin
            // abort wins over the compare that would otherwise happen on this edge.
            if (abort) begin
               state_d = StIdle;
               vec_d   = '0;
            end else if (sample) begin
               if (y != tbl_q[vec_q]) begin
                  if (err_q != ErrMax) err_d = err_q + 1'b1;
                  if (err_q == '0) ff_d = vec_q;
`ifdef GATE_SWEEP_LOG_EN
                  mask_d[vec_q] = 1'b1;
`endif
               end
               if (vec_q == LastVec) begin
                  state_d = StDone;
               end else begin
                  vec_d = vec_q + 1'b1;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
            vec_d   = '0;
         end
         default: begin
            state_d = StIdle;
            vec_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         tbl_q   <= '0;
         vec_q   <= '0;
         err_q   <= '0;
         ff_q    <= '0;
`ifdef GATE_SWEEP_LOG_EN
         mask_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         err_q   <= err_d;
         ff_q    <= ff_d;
`ifdef GATE_SWEEP_LOG_EN
         mask_q  <= mask_d;
`endif
         if (accept) tbl_q <= truth_tbl;
      end
   end

   assign vec_out    = vec_q;
   assign busy       = (state_q == StRun);
   assign done       = (state_q == StDone) && !abort;
   assign pass       = (err_q == '0);
   assign err_cnt    = err_q;
   assign first_fail = ff_q;
`ifdef GATE_SWEEP_LOG_EN
   assign fail_mask  = mask_q;
`endif

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Randomized self-checking bench for gate_sweep_ctrl: three instances (2x4, 2x1, 3x3 geometry).
`timescale 1ns/1ps
module tb_gate_sweep_ctrl;
   import gate_sweep_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   // Main instance: WIDTH 2, DWELL 4
   logic       start_m = 1'b0, abort_m = 1'b0;
   logic [3:0] tbl_m = '0, gut_m = '0;
   logic       y_m, busy_m, done_m, pass_m;
   logic [1:0] vec_m, ff_m;
   logic [2:0] err_m;
`ifdef GATE_SWEEP_LOG_EN
   logic [3:0] mask_m;
`endif
   assign y_m = gut_m[vec_m];

   // Fast instance: WIDTH 2, DWELL 1
   logic       start_f = 1'b0, abort_f = 1'b0;
   logic [3:0] tbl_f = '0, gut_f = '0;
   logic       y_f, busy_f, done_f, pass_f;
   logic [1:0] vec_f, ff_f;
   logic [2:0] err_f;
`ifdef GATE_SWEEP_LOG_EN
   logic [3:0] mask_f;
`endif
   assign y_f = gut_f[vec_f];

   // Wide instance: WIDTH 3, DWELL 3
   logic       start_w = 1'b0, abort_w = 1'b0;
   logic [7:0] tbl_w = '0, gut_w = '0;
   logic       y_w, busy_w, done_w, pass_w;
   logic [2:0] vec_w, ff_w;
   logic [3:0] err_w;
`ifdef GATE_SWEEP_LOG_EN
   logic [7:0] mask_w;
`endif
   assign y_w = gut_w[vec_w];

   gate_sweep_ctrl #(.WIDTH(2), .DWELL(4)) u_main (
      .clk(clk), .rst_n(rst_n), .start(start_m), .abort(abort_m), .truth_tbl(tbl_m), .y(y_m),
      .vec_out(vec_m), .busy(busy_m), .done(done_m), .pass(pass_m), .err_cnt(err_m),
      .first_fail(ff_m)
`ifdef GATE_SWEEP_LOG_EN
      , .fail_mask(mask_m)
`endif
   );

   gate_sweep_ctrl #(.WIDTH(2), .DWELL(1)) u_fast (
      .clk(clk), .rst_n(rst_n), .start(start_f), .abort(abort_f), .truth_tbl(tbl_f), .y(y_f),
      .vec_out(vec_f), .busy(busy_f), .done(done_f), .pass(pass_f), .err_cnt(err_f),
      .first_fail(ff_f)
`ifdef GATE_SWEEP_LOG_EN
      , .fail_mask(mask_f)
`endif
   );

   gate_sweep_ctrl #(.WIDTH(3), .DWELL(3)) u_wide (
      .clk(clk), .rst_n(rst_n), .start(start_w), .abort(abort_w), .truth_tbl(tbl_w), .y(y_w),
      .vec_out(vec_w), .busy(busy_w), .done(done_w), .pass(pass_w), .err_cnt(err_w),
      .first_fail(ff_w)
`ifdef GATE_SWEEP_LOG_EN
      , .fail_mask(mask_w)
`endif
   );

   // Reference model: a mismatch on vector v is bit v of (expected ^ actual gate).
   function automatic int unsigned model_err(input logic [7:0] diff);
      return $countones(diff);
   endfunction

   function automatic int unsigned model_first(input logic [7:0] diff);
      for (int v = 0; v < 8; v++) if (diff[v]) return v;
      return 0;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      if ({vec_m, busy_m, done_m, pass_m, err_m, ff_m} !== 10'b00_0_0_1_000_00) begin
         n_err++;
         $display("FAIL reset_main got %b want 0000100000",
                  {vec_m, busy_m, done_m, pass_m, err_m, ff_m});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      n_vec++;
      if ({vec_f, busy_f, done_f, pass_f, err_f, ff_f} !== 10'b00_0_0_1_000_00) begin
         n_err++;
         $display("FAIL reset_fast got %b want 0000100000",
                  {vec_f, busy_f, done_f, pass_f, err_f, ff_f});
      end
      n_vec++;
      if ({vec_w, busy_w, done_w, pass_w, err_w, ff_w} !== 13'b000_0_0_1_0000_000) begin
         n_err++;
         $display("FAIL reset_wide got %b want 0000100000000",
                  {vec_w, busy_w, done_w, pass_w, err_w, ff_w});
      end
`ifdef GATE_SWEEP_LOG_EN
      n_vec++;
      if ({mask_m, mask_f, mask_w} !== 16'h0) begin
         n_err++;
         $display("FAIL reset_mask got %h want 0000", {mask_m, mask_f, mask_w});
      end
`endif
   endtask

   // Full sweep on the main instance; caller is 1 ns after an edge with the DUT idle.
   task automatic run_main(input logic [3:0] truth, input logic [3:0] gut);
      logic [3:0] diff;
      diff = truth ^ gut;
      tbl_m = truth;
      gut_m = gut;
      start_m = 1'b1;
      @(posedge clk); #1;
      start_m = 1'b0;
      tbl_m = 4'($urandom);
      for (int c = 0; c < 16; c++) begin
         n_vec++;
         if ({busy_m, done_m, vec_m} !== {1'b1, 1'b0, 2'(c / 4)}) begin
            n_err++;
            $display("FAIL main_trace c=%0d got %b want %b", c, {busy_m, done_m, vec_m},
                     {1'b1, 1'b0, 2'(c / 4)});
         end
         start_m = (c == 6);
         @(posedge clk); #1;
      end
      n_vec++;
      if ({busy_m, done_m, vec_m, pass_m, err_m, ff_m} !==
          {1'b0, 1'b1, 2'd3, diff == 4'h0, 3'(model_err(8'(diff))), 2'(model_first(8'(diff)))})
      begin
         n_err++;
         $display("FAIL main_done got %b want %b", {busy_m, done_m, vec_m, pass_m, err_m, ff_m},
                  {1'b0, 1'b1, 2'd3, diff == 4'h0, 3'(model_err(8'(diff))),
                   2'(model_first(8'(diff)))});
      end
`ifdef GATE_SWEEP_LOG_EN
      n_vec++;
      if (mask_m !== diff) begin
         n_err++;
         $display("FAIL main_mask got %b want %b", mask_m, diff);
      end
`endif
      start_m = 1'b1;
      @(posedge clk); #1;
      start_m = 1'b0;
      n_vec++;
      if ({busy_m, done_m, vec_m} !== 4'b0000) begin
         n_err++;
         $display("FAIL main_after_done got %b want 0000", {busy_m, done_m, vec_m});
      end
   endtask

   task automatic run_fast(input logic [3:0] truth, input logic [3:0] gut);
      logic [3:0] diff;
      diff = truth ^ gut;
      tbl_f = truth;
      gut_f = gut;
      start_f = 1'b1;
      @(posedge clk); #1;
      start_f = 1'b0;
      tbl_f = 4'($urandom);
      for (int c = 0; c < 4; c++) begin
         n_vec++;
         if ({busy_f, done_f, vec_f} !== {1'b1, 1'b0, 2'(c)}) begin
            n_err++;
            $display("FAIL fast_trace c=%0d got %b want %b", c, {busy_f, done_f, vec_f},
                     {1'b1, 1'b0, 2'(c)});
         end
         start_f = (c == 1);
         @(posedge clk); #1;
      end
      n_vec++;
      if ({busy_f, done_f, pass_f, err_f, ff_f} !==
          {1'b0, 1'b1, diff == 4'h0, 3'(model_err(8'(diff))), 2'(model_first(8'(diff)))}) begin
         n_err++;
         $display("FAIL fast_done got %b want %b", {busy_f, done_f, pass_f, err_f, ff_f},
                  {1'b0, 1'b1, diff == 4'h0, 3'(model_err(8'(diff))), 2'(model_first(8'(diff)))});
      end
`ifdef GATE_SWEEP_LOG_EN
      n_vec++;
      if (mask_f !== diff) begin
         n_err++;
         $display("FAIL fast_mask got %b want %b", mask_f, diff);
      end
`endif
      @(posedge clk); #1;
   endtask

   task automatic run_wide(input logic [7:0] truth, input logic [7:0] gut);
      logic [7:0] diff;
      diff = truth ^ gut;
      tbl_w = truth;
      gut_w = gut;
      start_w = 1'b1;
      @(posedge clk); #1;
      start_w = 1'b0;
      tbl_w = 8'($urandom);
      for (int c = 0; c < 24; c++) begin
         n_vec++;
         if ({busy_w, done_w, vec_w} !== {1'b1, 1'b0, 3'(c / 3)}) begin
            n_err++;
            $display("FAIL wide_trace c=%0d got %b want %b", c, {busy_w, done_w, vec_w},
                     {1'b1, 1'b0, 3'(c / 3)});
         end
         start_w = (c == 10);
         @(posedge clk); #1;
      end
      n_vec++;
      if ({busy_w, done_w, pass_w, err_w, ff_w} !==
          {1'b0, 1'b1, diff == 8'h0, 4'(model_err(diff)), 3'(model_first(diff))}) begin
         n_err++;
         $display("FAIL wide_done got %b want %b", {busy_w, done_w, pass_w, err_w, ff_w},
                  {1'b0, 1'b1, diff == 8'h0, 4'(model_err(diff)), 3'(model_first(diff))});
      end
`ifdef GATE_SWEEP_LOG_EN
      n_vec++;
      if (mask_w !== diff) begin
         n_err++;
         $display("FAIL wide_mask got %b want %b", mask_w, diff);
      end
`endif
      @(posedge clk); #1;
   endtask

   // Abort lands on the compare edge of vector 2, so only vectors 0 and 1 are counted.
   task automatic test_abort();
      logic [3:0] gut, diff;
      gut = 4'($urandom);
      diff = TblAnd ^ gut;
      tbl_m = TblAnd;
      gut_m = gut;
      start_m = 1'b1;
      @(posedge clk); #1;
      start_m = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      abort_m = 1'b1;
      @(posedge clk); #1;
      abort_m = 1'b0;
      n_vec++;
      if ({busy_m, done_m, vec_m, err_m, ff_m} !==
          {1'b0, 1'b0, 2'd0, 3'(model_err({6'b0, diff[1:0]})),
           2'(model_first({6'b0, diff[1:0]}))}) begin
         n_err++;
         $display("FAIL abort_state got %b want %b", {busy_m, done_m, vec_m, err_m, ff_m},
                  {1'b0, 1'b0, 2'd0, 3'(model_err({6'b0, diff[1:0]})),
                   2'(model_first({6'b0, diff[1:0]}))});
      end
      for (int c = 0; c < 6; c++) begin
         n_vec++;
         if ({busy_m, done_m} !== 2'b00) begin
            n_err++;
            $display("FAIL abort_quiet c=%0d got %b want 00", c, {busy_m, done_m});
         end
         start_m = (c == 3);
         abort_m = (c == 3);
         @(posedge clk); #1;
      end
      start_m = 1'b0;
      abort_m = 1'b0;
      run_main(TblAnd, 4'($urandom));
   endtask

   task automatic test_reset_mid_sweep();
      tbl_m = TblAnd;
      gut_m = TblAnd ^ 4'b0001;
      start_m = 1'b1;
      @(posedge clk); #1;
      start_m = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      n_vec++;
      if ({busy_m, vec_m, err_m} !== {1'b1, 2'd1, 3'd1}) begin
         n_err++;
         $display("FAIL rst_pre got %b want 101001", {busy_m, vec_m, err_m});
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({vec_m, busy_m, done_m, pass_m, err_m, ff_m} !== 10'b00_0_0_1_000_00) begin
         n_err++;
         $display("FAIL rst_mid got %b want 0000100000",
                  {vec_m, busy_m, done_m, pass_m, err_m, ff_m});
      end
`ifdef GATE_SWEEP_LOG_EN
      n_vec++;
      if (mask_m !== 4'h0) begin
         n_err++;
         $display("FAIL rst_mid_mask got %b want 0000", mask_m);
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_main(TblAnd, TblAnd);
   endtask

   initial begin
      test_reset();
      run_main(TblAnd, TblAnd);
      run_main(TblAnd, TblOr);
      test_abort();
      test_reset_mid_sweep();
      run_fast(TblXor, TblXor);
      run_wide(8'h80, 8'hFF);
      for (int i = 0; i < 4; i++) begin
         logic [7:0] t, g;
         t = 8'($urandom);
         g = $urandom_range(0, 1) ? t : 8'($urandom);
         run_main(t[3:0], g[3:0]);
         run_fast(t[7:4], g[7:4]);
         run_wide(t, g);
      end
      run_main(TblOr, TblOr);
      run_main(TblAnd, TblXor);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
